// File: rtl/scene_compositor.sv
// Layer compositor for the VGA output path: priority merge of overlay layers over a
// background, a 2-stage pix_en-qualified pipeline, and a frame-synchronous fade on scene change.
module scene_compositor #(
  parameter int NUM_LAYERS      = 3,
  parameter int NUM_SCENES      = 8,
  parameter int STATE_W         = 3,
  parameter int FADE_STEPS      = 4,
  parameter int FRAMES_PER_STEP = 2,
  parameter int FADE_ENABLE     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pix_en,
  input  logic                             frame_start,
  input  logic                             valid,
  input  logic [STATE_W-1:0]               scene_in,
  input  logic [NUM_SCENES*NUM_LAYERS-1:0] scene_mask,
  input  logic [NUM_LAYERS-1:0]            layer_valid,
  input  logic [NUM_LAYERS*12-1:0]         layer_pixel,
  input  logic [11:0]                      bg_pixel,
  output logic [3:0]                       vgaRed,
  output logic [3:0]                       vgaGreen,
  output logic [3:0]                       vgaBlue,
  output logic [STATE_W-1:0]               active_scene,
  output logic                             fade_busy
);

  localparam int LOG_STEPS = $clog2(FADE_STEPS);
  localparam int LVL_W     = LOG_STEPS + 1;
  localparam int PROD_W    = 4 + LOG_STEPS + 1;
  localparam int CNT_W     = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FADE_STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic             FIRST_WRAP = (FRAMES_PER_STEP == 1);

  typedef enum logic [1:0] {STEADY, FADE_OUT, FADE_IN} state_e;

  state_e             state_q, state_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [STATE_W-1:0] active_q, active_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [11:0]        px1_q;
  logic [LVL_W-1:0]   lvl1_q;
  logic [11:0]        rgb_q;

  logic               scene_change;
  logic               wrap;
  logic               start_out;
  logic [NUM_LAYERS-1:0] scene_en;
  logic [11:0]        sel_px;

  assign scene_change = (scene_in != active_q);
  assign wrap         = (cnt_q == CNT_LAST);

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    active_d  = active_q;
    cnt_d     = cnt_q;
    start_out = 1'b0;
    if (frame_start) begin
      case (state_q)
        STEADY: begin
          if (scene_change) begin
            if (FADE_ENABLE != 0) start_out = 1'b1;
            else                  active_d  = scene_in;
          end
        end
        FADE_OUT: begin
          if (level_q == '0) begin
            active_d = scene_in;
            state_d  = FADE_IN;
            cnt_d    = '0;
          end else begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (wrap) level_d = level_q - 1'b1;
          end
        end
        FADE_IN: begin
          if (scene_change) begin
            start_out = 1'b1;
          end else begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (wrap) begin
              level_d = level_q + 1'b1;
              if (level_q + 1'b1 == LVL_FULL) state_d = STEADY;
            end
          end
        end
        default: state_d = STEADY;
      endcase
      // The frame that starts (or reverses into) a fade-out is its first counted frame.
      if (start_out) begin
        state_d = FADE_OUT;
        cnt_d   = FIRST_WRAP ? '0 : CNT_W'(1);
        if (FIRST_WRAP && level_q != '0) level_d = level_q - 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= STEADY;
      level_q  <= LVL_FULL;
      active_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    scene_en = '0;
    for (int s = 0; s < NUM_SCENES; s++) begin
      if (active_q == STATE_W'(s)) scene_en = scene_mask[s*NUM_LAYERS +: NUM_LAYERS];
    end
  end

  // Walk from lowest priority upward so layer 0 wins when several qualify.
  always_comb begin
    sel_px = bg_pixel;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (layer_valid[k] && scene_en[k]) sel_px = layer_pixel[12*k +: 12];
    end
  end

  function automatic logic [3:0] scale(input logic [3:0] c, input logic [LVL_W-1:0] lvl);
    return 4'((PROD_W'(c) * PROD_W'(lvl)) >> LOG_STEPS);
  endfunction

  // NOTE: the pipeline is a handful of flops, not a memory, so it is cleared in reset too.
  always_ff @(posedge clk) begin
    if (rst) begin
      px1_q  <= '0;
      lvl1_q <= '0;
      rgb_q  <= '0;
    end else if (pix_en) begin
      px1_q  <= valid ? sel_px : 12'h000;
      lvl1_q <= level_q;
      rgb_q  <= {scale(px1_q[11:8], lvl1_q), scale(px1_q[7:4], lvl1_q), scale(px1_q[3:0], lvl1_q)};
    end
  end

  assign vgaRed       = rgb_q[11:8];
  assign vgaGreen     = rgb_q[7:4];
  assign vgaBlue      = rgb_q[3:0];
  assign active_scene = active_q;
  assign fade_busy    = (state_q != STEADY);

endmodule
